// File: rtl/vmem_arb_pkg.sv
// Shared state encoding, port IDs and watchdog limit for the frame-buffer burst arbiter.
// The watchdog limit is only used when VMEM_ARB_TIMEOUT_EN is defined.
package vmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    localparam logic PORT_WR = 1'b0;
    localparam logic PORT_RD = 1'b1;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'hFFFF;

endpackage

// File: rtl/vmem_arb_pick.sv
// Combinational winner selection: starvation override, then single urgent port, then round robin.
module vmem_arb_pick
    import vmem_arb_pkg::*;
(
    input  logic i_wr_req,
    input  logic i_rd_req,
    input  logic i_wr_urgent,
    input  logic i_rd_urgent,
    input  logic i_wr_starved,
    input  logic i_rd_starved,
    input  logic i_rr_ptr,
    output logic o_winner
);

    // i_rr_ptr names the port that has preference on the next tie.
    always_comb begin
        o_winner = i_rr_ptr;
        if (i_wr_req && !i_rd_req) begin
            o_winner = PORT_WR;
        end else if (i_rd_req && !i_wr_req) begin
            o_winner = PORT_RD;
        end else if (i_rd_starved) begin
            o_winner = PORT_RD;
        end else if (i_wr_starved) begin
            o_winner = PORT_WR;
        end else if (i_wr_urgent && !i_rd_urgent) begin
            o_winner = PORT_WR;
        end else if (i_rd_urgent && !i_wr_urgent) begin
            o_winner = PORT_RD;
        end
    end

endmodule

// File: rtl/vmem_burst_arbiter.sv
// Two-port (sensor write / scaler read) burst arbiter driving one memory command port.
// Define VMEM_ARB_TIMEOUT_EN to add the XFER watchdog and the sticky timeout_err flag.
//
// state   | meaning
// IDLE    | waiting for enable and a request; winner latched into cmd_* on exit
// CMD     | cmd_valid held until cmd_ready; grant pulse follows the handshake
// XFER    | counting mem_beat until beat cmd_len; done pulse follows the last beat
module vmem_burst_arbiter
    import vmem_arb_pkg::*;
#(
    parameter int ADDR_BITS    = 25,
    parameter int LEN_BITS     = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 mem_clk,
    input  logic                 mem_rst_n,
    input  logic                 enable,
    input  logic                 wr_req,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [LEN_BITS-1:0]  wr_len,
    input  logic                 wr_urgent,
    output logic                 wr_grant,
    output logic                 wr_done,
    input  logic                 rd_req,
    input  logic [ADDR_BITS-1:0] rd_addr,
    input  logic [LEN_BITS-1:0]  rd_len,
    input  logic                 rd_urgent,
    output logic                 rd_grant,
    output logic                 rd_done,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic                 cmd_wr,
    output logic [ADDR_BITS-1:0] cmd_addr,
    output logic [LEN_BITS-1:0]  cmd_len,
    input  logic                 mem_beat,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    state_t              r_state;
    logic                r_win;
    logic                r_rr_ptr;
    logic [SW-1:0]       r_wr_starve;
    logic [SW-1:0]       r_rd_starve;
    logic [LEN_BITS-1:0] r_beat_cnt;

    logic w_winner;
    logic w_timeout;
    logic w_burst_end;

    vmem_arb_pick u_pick (
        .i_wr_req     (wr_req),
        .i_rd_req     (rd_req),
        .i_wr_urgent  (wr_urgent),
        .i_rd_urgent  (rd_urgent),
        .i_wr_starved (r_wr_starve == STARVE_MAX),
        .i_rd_starved (r_rd_starve == STARVE_MAX),
        .i_rr_ptr     (r_rr_ptr),
        .o_winner     (w_winner)
    );

`ifdef VMEM_ARB_TIMEOUT_EN
    logic [15:0] r_wdog;

    assign w_timeout = (r_state == ST_XFER) && !mem_beat && (r_wdog == TIMEOUT_LIMIT);

    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            r_wdog      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (r_state != ST_XFER || mem_beat) begin
                r_wdog <= '0;
            end else if (r_wdog != TIMEOUT_LIMIT) begin
                r_wdog <= r_wdog + 16'd1;
            end
            if (w_timeout) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign w_burst_end = (mem_beat && (r_beat_cnt == cmd_len)) || w_timeout;

    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            r_state     <= ST_IDLE;
            r_win       <= PORT_WR;
            r_rr_ptr    <= PORT_WR;
            r_wr_starve <= '0;
            r_rd_starve <= '0;
            r_beat_cnt  <= '0;
            wr_grant    <= 1'b0;
            rd_grant    <= 1'b0;
            wr_done     <= 1'b0;
            rd_done     <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_wr      <= 1'b0;
            cmd_addr    <= '0;
            cmd_len     <= '0;
            busy        <= 1'b0;
        end else begin
            wr_grant <= 1'b0;
            rd_grant <= 1'b0;
            wr_done  <= 1'b0;
            rd_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A done pulse still showing keeps this IDLE cycle free of arbitration.
                    if (enable && (wr_req || rd_req) && !wr_done && !rd_done) begin
                        r_win     <= w_winner;
                        cmd_wr    <= (w_winner == PORT_WR);
                        cmd_addr  <= (w_winner == PORT_WR) ? wr_addr : rd_addr;
                        cmd_len   <= (w_winner == PORT_WR) ? wr_len : rd_len;
                        cmd_valid <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (cmd_ready) begin
                        cmd_valid  <= 1'b0;
                        wr_grant   <= (r_win == PORT_WR);
                        rd_grant   <= (r_win == PORT_RD);
                        r_beat_cnt <= '0;
                        r_rr_ptr   <= ~r_win;
                        r_state    <= ST_XFER;
                        if (r_win == PORT_WR) begin
                            r_wr_starve <= '0;
                            if (rd_req && r_rd_starve != STARVE_MAX) begin
                                r_rd_starve <= r_rd_starve + 1'b1;
                            end
                        end else begin
                            r_rd_starve <= '0;
                            if (wr_req && r_wr_starve != STARVE_MAX) begin
                                r_wr_starve <= r_wr_starve + 1'b1;
                            end
                        end
                    end
                end
                ST_XFER: begin
                    if (w_burst_end) begin
                        wr_done <= (r_win == PORT_WR);
                        rd_done <= (r_win == PORT_RD);
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (mem_beat) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vmem_burst_arbiter.sv
// Directed bench for vmem_burst_arbiter: a table of back-to-back bursts plus stall, enable-drop and reset sequences.
// Add the watchdog run by defining VMEM_ARB_TIMEOUT_EN for both bench and RTL.
module tb_vmem_burst_arbiter;

    logic        mem_clk = 1'b0;
    logic        mem_rst_n;
    logic        enable;
    logic        wr_req, wr_urgent, wr_grant, wr_done;
    logic [24:0] wr_addr;
    logic [7:0]  wr_len;
    logic        rd_req, rd_urgent, rd_grant, rd_done;
    logic [24:0] rd_addr;
    logic [7:0]  rd_len;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [24:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        mem_beat, busy, timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 mem_clk = ~mem_clk;

    vmem_burst_arbiter dut (
        .mem_clk     (mem_clk),
        .mem_rst_n   (mem_rst_n),
        .enable      (enable),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_len      (wr_len),
        .wr_urgent   (wr_urgent),
        .wr_grant    (wr_grant),
        .wr_done     (wr_done),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_len      (rd_len),
        .rd_urgent   (rd_urgent),
        .rd_grant    (rd_grant),
        .rd_done     (rd_done),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_wr      (cmd_wr),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .mem_beat    (mem_beat),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic       wr_req;
        logic       rd_req;
        logic       wr_urg;
        logic       rd_urg;
        logic [7:0] len;
        logic       exp_wr;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One complete burst from table entry idx, starting with the arbiter idle and no done showing.
    task automatic run_vec(input int idx);
        logic [24:0] exp_addr;
        int early_done;
        wr_req    = vecs[idx].wr_req;
        rd_req    = vecs[idx].rd_req;
        wr_urgent = vecs[idx].wr_urg;
        rd_urgent = vecs[idx].rd_urg;
        wr_addr   = 25'h0080000 + 25'(idx * 16);
        rd_addr   = 25'h1000000 + 25'(idx * 32);
        wr_len    = vecs[idx].len;
        rd_len    = vecs[idx].len;
        exp_addr  = vecs[idx].exp_wr ? wr_addr : rd_addr;
        tick();
        check($sformatf("v%0d cmd_valid", idx), 32'(cmd_valid), 32'd1);
        check($sformatf("v%0d cmd_wr", idx), 32'(cmd_wr), 32'(vecs[idx].exp_wr));
        check($sformatf("v%0d cmd_addr", idx), 32'(cmd_addr), 32'(exp_addr));
        check($sformatf("v%0d cmd_len", idx), 32'(cmd_len), 32'(vecs[idx].len));
        cmd_ready = 1'b1;
        tick();
        check($sformatf("v%0d grant", idx), {30'd0, wr_grant, rd_grant},
              {30'd0, vecs[idx].exp_wr, !vecs[idx].exp_wr});
        cmd_ready = 1'b0;
        if (vecs[idx].exp_wr) wr_req = 1'b0;
        else rd_req = 1'b0;
        early_done = 0;
        mem_beat = 1'b1;
        for (int b = 0; b <= int'(vecs[idx].len); b++) begin
            if (wr_done || rd_done) early_done++;
            tick();
        end
        mem_beat = 1'b0;
        check($sformatf("v%0d early done", idx), 32'(early_done), 32'd0);
        check($sformatf("v%0d done", idx), {30'd0, wr_done, rd_done},
              {30'd0, vecs[idx].exp_wr, !vecs[idx].exp_wr});
        check($sformatf("v%0d busy after", idx), 32'(busy), 32'd0);
        tick();
        check($sformatf("v%0d done pulse", idx), {30'd0, wr_done, rd_done}, 32'd0);
    endtask

    initial begin
        int stall_bad;
        int early_done;
        int idle_bad;
        int waited;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0};

        mem_rst_n = 1'b0;
        enable    = 1'b1;
        wr_req    = 1'b0; wr_urgent = 1'b0; wr_addr = '0; wr_len = '0;
        rd_req    = 1'b0; rd_urgent = 1'b0; rd_addr = '0; rd_len = '0;
        cmd_ready = 1'b0;
        mem_beat  = 1'b0;
        repeat (3) tick();
        check("reset outputs", {24'd0, wr_grant, wr_done, rd_grant, rd_done, cmd_valid, cmd_wr, busy, timeout_err}, 32'd0);
        mem_rst_n = 1'b1;
        tick();
        check("idle after reset", {30'd0, busy, cmd_valid}, 32'd0);

        for (int i = 0; i < 14; i++) run_vec(i);

        // Command stall: cmd_* must hold while cmd_ready is low; mem_beat during CMD is ignored.
        wr_req = 1'b1; wr_addr = 25'h0ABCDE; wr_len = 8'd0;
        rd_req = 1'b0; wr_urgent = 1'b0; rd_urgent = 1'b0;
        tick();
        wr_addr = 25'h1FFFFFF;
        mem_beat = 1'b1;
        stall_bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (!cmd_valid || cmd_addr != 25'h0ABCDE || wr_grant || rd_grant) stall_bad++;
            tick();
        end
        mem_beat = 1'b0;
        check("stall cmd stable", 32'(stall_bad), 32'd0);
        cmd_ready = 1'b1;
        tick();
        check("stall grant", 32'(wr_grant), 32'd1);
        cmd_ready = 1'b0; wr_req = 1'b0;
        check("stall still busy", {30'd0, busy, wr_done}, 32'd2);
        mem_beat = 1'b1;
        tick();
        mem_beat = 1'b0;
        check("len0 done", {30'd0, wr_done, busy}, 32'd2);
        tick();

        // Enable dropped mid-burst: 16-beat read completes, then no new command while enable is low.
        rd_req = 1'b1; rd_addr = 25'h1234560; rd_len = 8'd15;
        tick();
        check("len15 cmd", {6'd0, cmd_valid, cmd_addr}, {6'd0, 1'b1, 25'h1234560});
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0; rd_req = 1'b0;
        check("len15 grant", {30'd0, rd_grant, wr_grant}, 32'd2);
        enable = 1'b0;
        wr_req = 1'b1; wr_addr = 25'h0C0FFEE; wr_len = 8'd5;
        early_done = 0;
        for (int b = 0; b < 16; b++) begin
            if (rd_done || !busy) early_done++;
            mem_beat = 1'b1;
            tick();
            mem_beat = 1'b0;
            if (b % 4 == 1) begin
                if (rd_done || !busy) early_done++;
                tick();
            end
        end
        check("len15 early end", 32'(early_done), 32'd0);
        check("len15 rd_done", {30'd0, rd_done, busy}, 32'd2);
        idle_bad = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (cmd_valid || busy) idle_bad++;
        end
        check("disabled idle", 32'(idle_bad), 32'd0);
        enable = 1'b1;
        tick();
        check("reenable cmd", {29'd0, cmd_valid, cmd_wr, busy}, 32'd7);

        // Reset in the middle of a transfer clears every output at once.
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0; wr_req = 1'b0;
        mem_beat = 1'b1;
        tick();
        tick();
        check("mid xfer busy", 32'(busy), 32'd1);
        #2;
        mem_rst_n = 1'b0;
        #1;
        check("async reset outputs",
              {24'd0, wr_grant, wr_done, rd_grant, rd_done, cmd_valid, cmd_wr, busy, timeout_err}, 32'd0);
        check("async reset cmd", {7'd0, cmd_addr}, 32'd0);
        mem_beat = 1'b0;
        tick();
        mem_rst_n = 1'b1;
        tick();

`ifdef VMEM_ARB_TIMEOUT_EN
        wr_req = 1'b1; wr_addr = 25'h0000100; wr_len = 8'd2;
        tick();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0; wr_req = 1'b0;
        waited = 0;
        while (!wr_done && waited < 70000) begin
            tick();
            waited++;
        end
        check("timeout done", 32'(wr_done), 32'd1);
        check("timeout err", {30'd0, timeout_err, busy}, 32'd2);
        tick();
        check("timeout sticky", 32'(timeout_err), 32'd1);
`else
        waited = 0;
        check("timeout err off", 32'(timeout_err), 32'(waited));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vmem_burst_arbiter.md
Name: vmem_burst_arbiter

Overview:
- Single-clock arbiter on the memory-controller side of the video frame buffer.
- Shares one burst command port between two requesters: the sensor write path (wr) and the scaler read path (rd).
- Each requester supplies a full burst address, already composed from its frame base plus line offset.
- The block selects one requester, issues one command, counts data beats to burst end, then re-arbitrates.

Parameters:
ADDR_BITS, 25, width of burst start address
LEN_BITS, 8, width of burst length field (encoded as beats-1)
STARVE_LIMIT, 4, consecutive grants one port may win while the other waits

Ports:
mem_clk  in  1  arbiter clock
mem_rst_n  in  1  asynchronous active-low reset
enable  in  1  permits new arbitration
wr_req  in  1  write burst request, held high until wr_grant
wr_addr  in  ADDR_BITS  write burst start address
wr_len  in  LEN_BITS  write burst beats-1
wr_urgent  in  1  write FIFO near full
wr_grant  out  1  one-cycle pulse, write command accepted
wr_done  out  1  one-cycle pulse, last write beat transferred
rd_req  in  1  read burst request, held high until rd_grant
rd_addr  in  ADDR_BITS  read burst start address
rd_len  in  LEN_BITS  read burst beats-1
rd_urgent  in  1  read FIFO near empty
rd_grant  out  1  one-cycle pulse, read command accepted
rd_done  out  1  one-cycle pulse, last read beat transferred
cmd_valid  out  1  command valid to memory controller
cmd_ready  in  1  controller accepts command
cmd_wr  out  1  1 = write, 0 = read
cmd_addr  out  ADDR_BITS  command start address
cmd_len  out  LEN_BITS  command beats-1
mem_beat  in  1  one data beat transferred for the current burst
busy  out  1  high in every state except IDLE
timeout_err  out  1  sticky burst-timeout flag (tied 0 when the optional feature is off)

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; round-robin pointer set to wr; starvation counters 0; beat counter 0.
- States and transitions:
  - IDLE: if enable and (wr_req or rd_req), select a winner, latch its addr/len/direction into the cmd_* registers, and go to CMD. cmd_valid is high on the cycle after req is sampled (one-cycle latency).
  - CMD: cmd_valid is held high with cmd_* stable until cmd_ready. On the cmd_valid and cmd_ready cycle, pulse the winner's grant, clear the beat counter, and go to XFER.
  - XFER: each mem_beat increments the beat counter. A mem_beat while the counter equals cmd_len pulses the winner's done and returns to IDLE.
- Winner selection, in priority order:
  1. The loser's starvation counter equals STARVE_LIMIT: the loser wins.
  2. Exactly one urgent requester: that requester wins.
  3. Otherwise round robin: the port not granted last wins; a single requesting port wins outright.
- Starvation counter for a port: increments when the other port is granted while this port requests; clears when this port is granted; saturates at STARVE_LIMIT.
- Round-robin pointer updates at grant.
- A requester must keep req/addr/len stable until its grant. The arbiter ignores changes after latching in IDLE.
- mem_beat is ignored in IDLE and CMD.
- Minimum burst is one beat (len = 0); maximum is 2^LEN_BITS beats. The beat counter is LEN_BITS wide with no wrap hazard, because the compare happens before increment.
- Deasserting enable mid-burst lets CMD/XFER complete normally; the block then stays in IDLE until enable returns.
- A req dropped before its grant is a protocol error. The latched command is still issued; no recovery is performed.
- done and the next arbitration never share a cycle. IDLE is visited for at least one cycle between bursts.

Optional Feature:
- Macro VMEM_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counter runs in XFER and clears on each mem_beat.
  - When it reaches 16'hFFFF, the block pulses the winner's done, sets timeout_err (sticky until reset), and returns to IDLE.
- Undefined: no watchdog logic; timeout_err is constant 0; a hung burst stalls in XFER indefinitely.

Decomposition:
- Package vmem_arb_pkg holds:
  - state encoding constants ST_IDLE = 2'd0, ST_CMD = 2'd1, ST_XFER = 2'd2;
  - port ID constants PORT_WR = 1'b0, PORT_RD = 1'b1;
  - the default timeout constant.
- One sub-module, vmem_arb_pick: a combinational winner selection taking both req, both urgent, both starvation-limit flags and the round-robin pointer, and returning the winner ID.
- The FSM, counters and command registers stay in the top module.

Test Plan:
- Single write, wr_req with addr 25'h0080000 and len 8'd3, cmd_ready high: cmd_valid 1 cycle after req, wr_grant 1 cycle, 4 mem_beat, wr_done on 4th beat, busy low next cycle.
- Both req, neither urgent, repeated 4 bursts: grants alternate wr, rd, wr, rd.
- wr_urgent held with both requesting continuously: wr wins 4 consecutive bursts, then rd wins the 5th (starvation limit), then wr again.
- cmd_ready held low 10 cycles: cmd_valid and cmd_addr stable all 10 cycles, no grant until ready.
- enable dropped during XFER of a len = 15 read: all 16 beats complete and rd_done pulses; no new cmd_valid while enable stays low despite wr_req.
- mem_rst_n asserted mid-XFER: outputs 0 immediately. With VMEM_ARB_TIMEOUT_EN defined, a separate run with no beats for 65535 cycles pulses done and sets timeout_err.
